// File: rtl/open_list_pkg.sv
`default_nettype none
// ============================================================================
// open_list_pkg : op codes, FSM states, slot selects and key ordering
// Rev 1.0
// ============================================================================
package open_list_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_UPDATE  = 3'd4
  } op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_UPD  = 1'b1
  } olq_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_PREV = 2'd1,
    SEL_NEXT = 2'd2,
    SEL_NEW  = 2'd3
  } slot_sel_e;

  // Keys are zero-extended by the caller; comparison is unsigned and strict.
  function automatic logic better(input logic [63:0] a, input logic [63:0] b,
                                  input logic min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/open_list_pq_slot.sv
`default_nettype none
// ============================================================================
// open_list_pq_slot : one queue entry with ordering and coordinate match flags
// Rev 1.0
// ============================================================================
module open_list_pq_slot
  import open_list_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int COORD_I_W  = 4,
  parameter int COORD_J_W  = 4,
  parameter bit MIN_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  slot_sel_e             i_sel,
  input  logic                  i_prev_valid,
  input  logic [DATA_WIDTH-1:0] i_prev_f,
  input  logic [COORD_I_W-1:0]  i_prev_i,
  input  logic [COORD_J_W-1:0]  i_prev_j,
  input  logic                  i_next_valid,
  input  logic [DATA_WIDTH-1:0] i_next_f,
  input  logic [COORD_I_W-1:0]  i_next_i,
  input  logic [COORD_J_W-1:0]  i_next_j,
  input  logic [DATA_WIDTH-1:0] i_new_f,
  input  logic [COORD_I_W-1:0]  i_new_i,
  input  logic [COORD_J_W-1:0]  i_new_j,
  input  logic [COORD_I_W-1:0]  i_cmp_i,
  input  logic [COORD_J_W-1:0]  i_cmp_j,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_f,
  output logic [COORD_I_W-1:0]  o_i,
  output logic [COORD_J_W-1:0]  o_j,
  output logic                  o_not_worse,
  output logic                  o_coord_match
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_f;
  logic [COORD_I_W-1:0]  r_i;
  logic [COORD_J_W-1:0]  r_j;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_f     <= '1;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      case (i_sel)
        SEL_PREV: begin
          r_valid <= i_prev_valid;
          r_f     <= i_prev_f;
          r_i     <= i_prev_i;
          r_j     <= i_prev_j;
        end
        SEL_NEXT: begin
          r_valid <= i_next_valid;
          r_f     <= i_next_f;
          r_i     <= i_next_i;
          r_j     <= i_next_j;
        end
        SEL_NEW: begin
          r_valid <= 1'b1;
          r_f     <= i_new_f;
          r_i     <= i_new_i;
          r_j     <= i_new_j;
        end
        default: ;
      endcase
    end
  end

  assign o_valid       = r_valid;
  assign o_f           = r_f;
  assign o_i           = r_i;
  assign o_j           = r_j;
  // Equal keys count as not worse so a new node lands behind its peers.
  assign o_not_worse   = r_valid && !better(64'(i_new_f), 64'(r_f), MIN_FIRST);
  assign o_coord_match = r_valid && (r_i == i_cmp_i) && (r_j == i_cmp_j);

endmodule
`default_nettype wire

// File: rtl/open_list_pq.sv
`default_nettype none
// ============================================================================
// open_list_pq : sorted open-list priority queue with decrease-key UPDATE
// Rev 1.0
// ============================================================================
module open_list_pq
  import open_list_pkg::*;
#(
  parameter int QUEUE_SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int MAP_WIDTH  = 16,
  parameter int MAP_HEIGHT = 16,
  parameter bit MIN_FIRST  = 1'b1,
  localparam int COORD_I_W = $clog2(MAP_WIDTH),
  localparam int COORD_J_W = $clog2(MAP_HEIGHT),
  localparam int CNT_W     = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_valid,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_node_f,
  input  logic [COORD_I_W-1:0]  i_node_i,
  input  logic [COORD_J_W-1:0]  i_node_j,
  output logic                  o_ready_push,
  output logic                  o_ready_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_node_f,
  output logic [COORD_I_W-1:0]  o_node_i,
  output logic [COORD_J_W-1:0]  o_node_j,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_drop
);

  localparam logic [CNT_W-1:0] c_none = CNT_W'(QUEUE_SIZE);

  olq_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic                  r_drop, w_drop_nxt;
  logic                  r_upd_found;
  logic [CNT_W-1:0]      r_upd_idx;
  logic [DATA_WIDTH-1:0] r_upd_f;
  logic [COORD_I_W-1:0]  r_upd_i;
  logic [COORD_J_W-1:0]  r_upd_j;
  logic                  w_upd_load;

  logic                  w_slot_v [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] w_slot_f [QUEUE_SIZE];
  logic [COORD_I_W-1:0]  w_slot_i [QUEUE_SIZE];
  logic [COORD_J_W-1:0]  w_slot_j [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] w_nw, w_match;

  op_e                   w_op;
  logic                  w_ready_push, w_ready_pop;
  logic [DATA_WIDTH-1:0] w_new_f;
  logic [COORD_I_W-1:0]  w_new_i;
  logic [COORD_J_W-1:0]  w_new_j;
  logic [CNT_W-1:0]      w_rem_idx, w_ins_pos, w_excl_idx;
  logic [CNT_W-1:0]      w_q_all, w_q_excl, w_match_idx;
  logic                  w_found;
  logic [DATA_WIDTH-1:0] w_upd_slot_f;

  assign w_op         = op_e'(i_op);
  assign w_ready_push = (r_state == ST_IDLE) && (r_count != c_none);
  assign w_ready_pop  = (r_state == ST_IDLE) && (r_count != '0);

  // While UPD is pending, the registered node is the one being placed.
  assign w_new_f    = (r_state == ST_UPD) ? r_upd_f : i_node_f;
  assign w_new_i    = (r_state == ST_UPD) ? r_upd_i : i_node_i;
  assign w_new_j    = (r_state == ST_UPD) ? r_upd_j : i_node_j;
  assign w_excl_idx = (r_state == ST_UPD) ? r_upd_idx : '0;

  // Insert position: not-worse count, optionally ignoring the slot being removed.
  always_comb begin
    w_q_all      = '0;
    w_q_excl     = '0;
    w_found      = 1'b0;
    w_match_idx  = '0;
    w_upd_slot_f = '1;
    for (int k = 0; k < QUEUE_SIZE; k++) begin
      w_q_all = w_q_all + CNT_W'(w_nw[k]);
      if (CNT_W'(k) != w_excl_idx) w_q_excl = w_q_excl + CNT_W'(w_nw[k]);
      if (CNT_W'(k) == r_upd_idx) w_upd_slot_f = w_slot_f[k];
    end
    for (int k = QUEUE_SIZE - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_found     = 1'b1;
        w_match_idx = CNT_W'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_drop_nxt  = 1'b0;
    w_rem_idx   = c_none;
    w_ins_pos   = c_none;
    w_upd_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          case (w_op)
            OP_PUSH: begin
              if (w_ready_push) begin
                w_ins_pos   = w_q_all;
                w_count_nxt = r_count + CNT_W'(1);
              end else w_drop_nxt = 1'b1;
            end
            OP_POP: begin
              if (w_ready_pop) begin
                w_rem_idx   = '0;
                w_count_nxt = r_count - CNT_W'(1);
              end else w_drop_nxt = 1'b1;
            end
            OP_REPLACE: begin
              if (w_ready_pop) begin
                w_rem_idx = '0;
                w_ins_pos = w_q_excl;
              end else w_drop_nxt = 1'b1;
            end
            OP_UPDATE: begin
              if (w_ready_push) begin
                w_upd_load  = 1'b1;
                w_state_nxt = ST_UPD;
              end else w_drop_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_UPD: begin
        w_state_nxt = ST_IDLE;
        if (i_valid && (w_op != OP_NOP)) w_drop_nxt = 1'b1;
        if (r_upd_found) begin
          if (better(64'(r_upd_f), 64'(w_upd_slot_f), MIN_FIRST)) begin
            w_rem_idx = r_upd_idx;
            w_ins_pos = w_q_excl;
          end else w_drop_nxt = 1'b1;
        end else begin
          w_ins_pos   = w_q_all;
          w_count_nxt = r_count + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_drop      <= 1'b0;
      r_upd_found <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_f     <= '0;
      r_upd_i     <= '0;
      r_upd_j     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_drop  <= w_drop_nxt;
      if (w_upd_load) begin
        r_upd_found <= w_found;
        r_upd_idx   <= w_match_idx;
        r_upd_f     <= i_node_f;
        r_upd_i     <= i_node_i;
        r_upd_j     <= i_node_j;
      end
    end
  end

  // Slot k after a remove at r and insert at q: k<q takes the compacted entry,
  // k==q the new node, k>q the compacted entry shifted down by one.
  for (genvar k = 0; k < QUEUE_SIZE; k++) begin : g_slot
    localparam logic [CNT_W-1:0] c_k = CNT_W'(k);
    slot_sel_e             w_sel;
    logic                  w_pv, w_nv;
    logic [DATA_WIDTH-1:0] w_pf, w_nf;
    logic [COORD_I_W-1:0]  w_pi, w_ni;
    logic [COORD_J_W-1:0]  w_pj, w_nj;

    if (k == 0) begin : g_head
      assign w_pv = 1'b0;
      assign w_pf = '1;
      assign w_pi = '0;
      assign w_pj = '0;
    end else begin : g_prev
      assign w_pv = w_slot_v[k-1];
      assign w_pf = w_slot_f[k-1];
      assign w_pi = w_slot_i[k-1];
      assign w_pj = w_slot_j[k-1];
    end

    if (k == QUEUE_SIZE - 1) begin : g_tail
      assign w_nv = 1'b0;
      assign w_nf = '1;
      assign w_ni = '0;
      assign w_nj = '0;
    end else begin : g_next
      assign w_nv = w_slot_v[k+1];
      assign w_nf = w_slot_f[k+1];
      assign w_ni = w_slot_i[k+1];
      assign w_nj = w_slot_j[k+1];
    end

    always_comb begin
      w_sel = SEL_HOLD;
      if (c_k < w_ins_pos)       w_sel = (c_k < w_rem_idx) ? SEL_HOLD : SEL_NEXT;
      else if (c_k == w_ins_pos) w_sel = SEL_NEW;
      else                       w_sel = (c_k <= w_rem_idx) ? SEL_PREV : SEL_HOLD;
    end

    open_list_pq_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .COORD_I_W  (COORD_I_W),
      .COORD_J_W  (COORD_J_W),
      .MIN_FIRST  (MIN_FIRST)
    ) u_slot (
      .clk           (CLK),
      .rst           (RST),
      .i_sel         (w_sel),
      .i_prev_valid  (w_pv),
      .i_prev_f      (w_pf),
      .i_prev_i      (w_pi),
      .i_prev_j      (w_pj),
      .i_next_valid  (w_nv),
      .i_next_f      (w_nf),
      .i_next_i      (w_ni),
      .i_next_j      (w_nj),
      .i_new_f       (w_new_f),
      .i_new_i       (w_new_i),
      .i_new_j       (w_new_j),
      .i_cmp_i       (i_node_i),
      .i_cmp_j       (i_node_j),
      .o_valid       (w_slot_v[k]),
      .o_f           (w_slot_f[k]),
      .o_i           (w_slot_i[k]),
      .o_j           (w_slot_j[k]),
      .o_not_worse   (w_nw[k]),
      .o_coord_match (w_match[k])
    );
  end

  assign o_ready_push = w_ready_push;
  assign o_ready_pop  = w_ready_pop;
  assign o_valid      = w_slot_v[0];
  assign o_node_f     = w_slot_f[0];
  assign o_node_i     = w_slot_i[0];
  assign o_node_j     = w_slot_j[0];
  assign o_count      = r_count;
  assign o_full       = (r_count == c_none);
  assign o_empty      = (r_count == '0);
  assign o_drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_open_list_pq.sv
`default_nettype none
// ============================================================================
// tb_open_list_pq : directed self-checking bench for open_list_pq
// Rev 1.0
// ============================================================================
module tb_open_list_pq;
  import open_list_pkg::*;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int JW = 4;
  localparam int CW = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, i_valid;
  logic [2:0]    i_op;
  logic [DW-1:0] i_node_f;
  logic [IW-1:0] i_node_i;
  logic [JW-1:0] i_node_j;
  logic          o_ready_push, o_ready_pop, o_valid, o_full, o_empty, o_drop;
  logic [DW-1:0] o_node_f;
  logic [IW-1:0] o_node_i;
  logic [JW-1:0] o_node_j;
  logic [CW-1:0] o_count;

  logic          m_rst, m_valid_in;
  logic [2:0]    m_op;
  logic [DW-1:0] m_f_in;
  logic [IW-1:0] m_i_in;
  logic [JW-1:0] m_j_in;
  logic          m_ready_push, m_ready_pop, m_valid, m_full, m_empty, m_drop;
  logic [DW-1:0] m_f;
  logic [IW-1:0] m_i;
  logic [JW-1:0] m_j;
  logic [CW-1:0] m_count;

  open_list_pq #(.QUEUE_SIZE(8), .DATA_WIDTH(DW), .MAP_WIDTH(16), .MAP_HEIGHT(16),
                 .MIN_FIRST(1'b1)) u_dut (
    .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_op(i_op),
    .i_node_f(i_node_f), .i_node_i(i_node_i), .i_node_j(i_node_j),
    .o_ready_push(o_ready_push), .o_ready_pop(o_ready_pop), .o_valid(o_valid),
    .o_node_f(o_node_f), .o_node_i(o_node_i), .o_node_j(o_node_j),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_drop(o_drop)
  );

  open_list_pq #(.QUEUE_SIZE(8), .DATA_WIDTH(DW), .MAP_WIDTH(16), .MAP_HEIGHT(16),
                 .MIN_FIRST(1'b0)) u_dut_max (
    .CLK(CLK), .RST(m_rst), .i_valid(m_valid_in), .i_op(m_op),
    .i_node_f(m_f_in), .i_node_i(m_i_in), .i_node_j(m_j_in),
    .o_ready_push(m_ready_push), .o_ready_pop(m_ready_pop), .o_valid(m_valid),
    .o_node_f(m_f), .o_node_i(m_i), .o_node_j(m_j),
    .o_count(m_count), .o_full(m_full), .o_empty(m_empty), .o_drop(m_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one request, let it be sampled, then sample outputs 1 ns later.
  task automatic drive(input logic [2:0] op, input logic [DW-1:0] f,
                       input logic [IW-1:0] ii, input logic [JW-1:0] jj);
    @(negedge CLK);
    i_valid = 1'b1; i_op = op; i_node_f = f; i_node_i = ii; i_node_j = jj;
    @(posedge CLK); #1;
    i_valid = 1'b0; i_op = OP_NOP;
  endtask

  task automatic m_drive(input logic [2:0] op, input logic [DW-1:0] f,
                         input logic [IW-1:0] ii, input logic [JW-1:0] jj);
    @(negedge CLK);
    m_valid_in = 1'b1; m_op = op; m_f_in = f; m_i_in = ii; m_j_in = jj;
    @(posedge CLK); #1;
    m_valid_in = 1'b0; m_op = OP_NOP;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [DW-1:0] f,
                            input logic [IW-1:0] ii, input logic [JW-1:0] jj);
    check_eq({tag, ".f"}, 32'(o_node_f), 32'(f));
    check_eq({tag, ".i"}, 32'(o_node_i), 32'(ii));
    check_eq({tag, ".j"}, 32'(o_node_j), 32'(jj));
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] f);
    check_eq({tag, ".f"}, 32'(o_node_f), 32'(f));
    drive(OP_POP, '0, '0, '0);
  endtask

  initial begin
    RST = 1'b1; i_valid = 1'b0; i_op = OP_NOP; i_node_f = '0; i_node_i = '0; i_node_j = '0;
    m_rst = 1'b1; m_valid_in = 1'b0; m_op = OP_NOP; m_f_in = '0; m_i_in = '0; m_j_in = '0;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0; m_rst = 1'b0;

    // Reset state
    check_eq("rst.valid", 32'(o_valid), 32'd0);
    check_eq("rst.empty", 32'(o_empty), 32'd1);
    check_eq("rst.full", 32'(o_full), 32'd0);
    check_eq("rst.drop", 32'(o_drop), 32'd0);
    check_eq("rst.rdy_push", 32'(o_ready_push), 32'd1);
    check_eq("rst.rdy_pop", 32'(o_ready_pop), 32'd0);
    check_eq("rst.f", 32'(o_node_f), 32'hFFFF);
    check_eq("rst.count", 32'(o_count), 32'd0);

    // Pushes with a tie: FIFO among equal keys
    drive(OP_PUSH, 16'd5, 4'd1, 4'd0);
    check_head("t1.first", 16'd5, 4'd1, 4'd0);
    drive(OP_PUSH, 16'd3, 4'd2, 4'd0);
    drive(OP_PUSH, 16'd9, 4'd3, 4'd0);
    drive(OP_PUSH, 16'd3, 4'd4, 4'd0);
    check_head("t1.head", 16'd3, 4'd2, 4'd0);
    check_eq("t1.count", 32'(o_count), 32'd4);
    drive(OP_POP, '0, '0, '0);
    check_head("t1.tie2", 16'd3, 4'd4, 4'd0);
    drive(OP_POP, '0, '0, '0);
    pop_check("t1.p5", 16'd5);
    pop_check("t1.p9", 16'd9);
    check_eq("t1.empty", 32'(o_empty), 32'd1);

    // Fill, overflow drop, drain ascending
    do_reset();
    drive(OP_PUSH, 16'd7,  4'd0, 4'd1);
    drive(OP_PUSH, 16'd2,  4'd1, 4'd1);
    drive(OP_PUSH, 16'd15, 4'd2, 4'd1);
    drive(OP_PUSH, 16'd4,  4'd3, 4'd1);
    drive(OP_PUSH, 16'd11, 4'd4, 4'd1);
    drive(OP_PUSH, 16'd0,  4'd5, 4'd1);
    drive(OP_PUSH, 16'd9,  4'd6, 4'd1);
    drive(OP_PUSH, 16'd4,  4'd7, 4'd1);
    check_eq("t2.full", 32'(o_full), 32'd1);
    check_eq("t2.rdy_push", 32'(o_ready_push), 32'd0);
    drive(OP_PUSH, 16'd1, 4'd8, 4'd8);
    check_eq("t2.drop", 32'(o_drop), 32'd1);
    check_eq("t2.count", 32'(o_count), 32'd8);
    check_head("t2.head", 16'd0, 4'd5, 4'd1);
    tick();
    check_eq("t2.drop_end", 32'(o_drop), 32'd0);
    pop_check("t2.p0", 16'd0);
    pop_check("t2.p2", 16'd2);
    check_head("t2.p4a", 16'd4, 4'd3, 4'd1);
    drive(OP_POP, '0, '0, '0);
    check_head("t2.p4b", 16'd4, 4'd7, 4'd1);
    drive(OP_POP, '0, '0, '0);
    pop_check("t2.p7", 16'd7);
    pop_check("t2.p9", 16'd9);
    pop_check("t2.p11", 16'd11);
    pop_check("t2.p15", 16'd15);
    check_eq("t2.empty", 32'(o_empty), 32'd1);
    drive(OP_POP, '0, '0, '0);
    check_eq("t2.pop_empty_drop", 32'(o_drop), 32'd1);
    drive(OP_PUSH, 16'hFFFF, 4'd9, 4'd9);
    check_eq("t2.max_key_valid", 32'(o_valid), 32'd1);
    check_eq("t2.max_key_count", 32'(o_count), 32'd1);

    // UPDATE: decrease-key at the tail, with a request ignored mid-update
    do_reset();
    drive(OP_PUSH, 16'd4, 4'd1, 4'd1);
    drive(OP_PUSH, 16'd7, 4'd2, 4'd2);
    drive(OP_PUSH, 16'd9, 4'd3, 4'd3);
    drive(OP_UPDATE, 16'd2, 4'd3, 4'd3);
    check_eq("t3.upd_rdy_push", 32'(o_ready_push), 32'd0);
    check_eq("t3.upd_rdy_pop", 32'(o_ready_pop), 32'd0);
    check_head("t3.upd_hold", 16'd4, 4'd1, 4'd1);
    i_valid = 1'b1; i_op = OP_PUSH; i_node_f = 16'd1; i_node_i = 4'd9; i_node_j = 4'd9;
    tick();
    i_valid = 1'b0; i_op = OP_NOP;
    check_head("t3.upd_head", 16'd2, 4'd3, 4'd3);
    check_eq("t3.upd_count", 32'(o_count), 32'd3);
    check_eq("t3.busy_drop", 32'(o_drop), 32'd1);
    check_eq("t3.rdy_back", 32'(o_ready_push), 32'd1);
    // UPDATE of an absent node behaves as PUSH
    drive(OP_UPDATE, 16'd8, 4'd1, 4'd2);
    tick();
    check_eq("t3.ins_count", 32'(o_count), 32'd4);
    check_eq("t3.ins_drop", 32'(o_drop), 32'd0);
    // Not-better UPDATE is discarded
    drive(OP_UPDATE, 16'd10, 4'd2, 4'd2);
    tick();
    check_eq("t4.discard_drop", 32'(o_drop), 32'd1);
    check_eq("t4.discard_count", 32'(o_count), 32'd4);
    // Decrease-key in the middle of the queue: 7@(2,2) -> 5
    drive(OP_UPDATE, 16'd5, 4'd2, 4'd2);
    tick();
    check_eq("t4.mid_count", 32'(o_count), 32'd4);
    pop_check("t4.p2", 16'd2);
    check_head("t4.p4", 16'd4, 4'd1, 4'd1);
    drive(OP_POP, '0, '0, '0);
    check_head("t4.p5", 16'd5, 4'd2, 4'd2);
    drive(OP_POP, '0, '0, '0);
    check_head("t4.p8", 16'd8, 4'd1, 4'd2);
    drive(OP_POP, '0, '0, '0);
    check_eq("t4.empty", 32'(o_empty), 32'd1);

    // REPLACE
    do_reset();
    drive(OP_PUSH, 16'd4, 4'd1, 4'd1);
    drive(OP_PUSH, 16'd7, 4'd2, 4'd2);
    drive(OP_PUSH, 16'd9, 4'd3, 4'd3);
    drive(OP_REPLACE, 16'd6, 4'd5, 4'd5);
    check_head("t5.head", 16'd6, 4'd5, 4'd5);
    check_eq("t5.count", 32'(o_count), 32'd3);
    pop_check("t5.p6", 16'd6);
    pop_check("t5.p7", 16'd7);
    pop_check("t5.p9", 16'd9);
    drive(OP_REPLACE, 16'd1, 4'd1, 4'd1);
    check_eq("t5.empty_drop", 32'(o_drop), 32'd1);
    check_eq("t5.empty_count", 32'(o_count), 32'd0);
    check_eq("t5.empty_valid", 32'(o_valid), 32'd0);

    // Largest-first build, then reset while an UPDATE is in flight
    m_drive(OP_PUSH, 16'd5, 4'd1, 4'd1);
    m_drive(OP_PUSH, 16'd3, 4'd2, 4'd2);
    m_drive(OP_PUSH, 16'd9, 4'd3, 4'd3);
    check_eq("t6.max_head_f", 32'(m_f), 32'd9);
    check_eq("t6.max_head_i", 32'(m_i), 32'd3);
    check_eq("t6.max_count", 32'(m_count), 32'd3);
    m_drive(OP_UPDATE, 16'd1, 4'd7, 4'd7);
    check_eq("t6.upd_rdy", 32'(m_ready_push), 32'd0);
    m_rst = 1'b1;
    tick();
    m_rst = 1'b0;
    check_eq("t6.rst_valid", 32'(m_valid), 32'd0);
    check_eq("t6.rst_rdy_push", 32'(m_ready_push), 32'd1);
    check_eq("t6.rst_count", 32'(m_count), 32'd0);
    tick();
    check_eq("t6.no_late_ins", 32'(m_count), 32'd0);
    check_eq("t6.no_late_drop", 32'(m_drop), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
